// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA test-path bit-reversal arbiter.
// State encoding, bus width and the reversal function.
package vga_pkg;

  localparam int VGA_BUS_W = 11;

  typedef enum logic [1:0] {
    ST_RR    = 2'd0,
    ST_HOLD0 = 2'd1,
    ST_HOLD1 = 2'd2
  } state_t;

  function automatic logic [VGA_BUS_W-1:0] bitrev(
    input logic [VGA_BUS_W-1:0] d
  );
    for (int n = 0; n < VGA_BUS_W; n++) begin
      bitrev[n] = d[VGA_BUS_W-1-n];
    end
  endfunction

endpackage

// File: rtl/vga_girovettori_arbiter_grant.sv
// Two-way combinational grant: round-robin, or pinned
// to one requester while a burst lock is held.
module rr_grant2
  import vga_pkg::*;
(
  input  logic [1:0] i_valid,
  input  state_t     i_state,
  input  logic       i_last,
  output logic       o_vld,
  output logic       o_id
);

  always_comb begin
    o_vld = 1'b0;
    o_id  = 1'b0;
    unique case (1'b1)
      (i_state == ST_HOLD0): begin
        o_vld = i_valid[0];
        o_id  = 1'b0;
      end
      (i_state == ST_HOLD1): begin
        o_vld = i_valid[1];
        o_id  = 1'b1;
      end
      default: begin
        o_vld = |i_valid;
        o_id  = (&i_valid) ? ~i_last : i_valid[1];
      end
    endcase
  end

endmodule

// File: rtl/vga_girovettori_arbiter.sv
// Shares one registered bit-reversal stage between two requesters,
// round-robin with optional burst lock; result tagged with winner id.
module vga_girovettori_arbiter
  import vga_pkg::*;
#(
  parameter int W     = VGA_BUS_W,
  parameter int CNT_W = 16
) (
  input  logic             clk20ns,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [W-1:0]     req0_data,
  input  logic             req0_lock,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [W-1:0]     req1_data,
  input  logic             req1_lock,
  output logic             req1_ready,
  input  logic [1:0]       cfg_rev,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             out_id,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  state_t         r_state;
  logic           r_last;
  logic           w_gnt_vld;
  logic           w_gnt_id;
  logic           w_can_accept;
  logic           w_acc0;
  logic           w_acc1;
  logic           w_acc;
  logic           w_acc_id;
  logic           w_lock;
  logic [W-1:0]   w_data;
  logic [W-1:0]   w_res;

  rr_grant2 u_grant (
    .i_valid ({req1_valid, req0_valid}),
    .i_state (r_state),
    .i_last  (r_last),
    .o_vld   (w_gnt_vld),
    .o_id    (w_gnt_id)
  );

  // Single output register, no skid: accept only when it drains.
  assign w_can_accept = !out_valid | out_ready;

  assign req0_ready = w_gnt_vld & !w_gnt_id
                    & req0_valid & w_can_accept;
  assign req1_ready = w_gnt_vld & w_gnt_id
                    & req1_valid & w_can_accept;

  assign w_acc0   = req0_valid & req0_ready;
  assign w_acc1   = req1_valid & req1_ready;
  assign w_acc    = w_acc0 | w_acc1;
  assign w_acc_id = w_acc1;
  assign w_data   = w_acc_id ? req1_data : req0_data;
  assign w_lock   = w_acc_id ? req1_lock : req0_lock;
  assign w_res    = cfg_rev[w_acc_id] ? bitrev(w_data) : w_data;

  always_ff @(posedge clk20ns or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 1'b0;
      cnt0      <= '0;
      cnt1      <= '0;
      r_state   <= ST_RR;
      r_last    <= 1'b1;
    end else if (w_acc) begin
      out_valid <= 1'b1;
      out_data  <= w_res;
      out_id    <= w_acc_id;
      r_last    <= w_acc_id;
      if (w_acc0) cnt0 <= cnt0 + CNT_W'(1);
      if (w_acc1) cnt1 <= cnt1 + CNT_W'(1);
      if (w_lock) begin
        r_state <= w_acc_id ? ST_HOLD1 : ST_HOLD0;
      end else begin
        r_state <= ST_RR;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_girovettori_arbiter.sv
// Self-checking bench for vga_girovettori_arbiter with a
// transaction-level reference model.
module tb_vga_girovettori_arbiter;

  logic        clk20ns = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [10:0] req0_data = '0;
  logic        req0_lock = 1'b0;
  logic        req1_valid = 1'b0;
  logic [10:0] req1_data = '0;
  logic        req1_lock = 1'b0;
  logic [1:0]  cfg_rev = '0;
  logic        out_ready = 1'b0;

  logic        req0_ready, req1_ready;
  logic        out_valid, out_id;
  logic [10:0] out_data;
  logic [15:0] cnt0, cnt1;

  logic        x_req0_ready, x_req1_ready;
  logic        x_out_valid, x_out_id;
  logic [10:0] x_out_data;
  logic [3:0]  x_cnt0, x_cnt1;

  int n_pass = 0;
  int n_total = 0;

  int m_own, m_last, m_ov, m_od, m_oid, m_c0, m_c1;

  always #10 clk20ns = ~clk20ns;

  vga_girovettori_arbiter dut (
    .clk20ns(clk20ns), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data),
    .req0_lock(req0_lock), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data),
    .req1_lock(req1_lock), .req1_ready(req1_ready),
    .cfg_rev(cfg_rev), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  vga_girovettori_arbiter #(.CNT_W(4)) dut_w (
    .clk20ns(clk20ns), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data),
    .req0_lock(req0_lock), .req0_ready(x_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data),
    .req1_lock(req1_lock), .req1_ready(x_req1_ready),
    .cfg_rev(cfg_rev), .out_valid(x_out_valid),
    .out_data(x_out_data), .out_id(x_out_id),
    .out_ready(out_ready), .cnt0(x_cnt0), .cnt1(x_cnt1)
  );

  // ---------------- reference model ----------------
  task automatic m_reset();
    m_own = -1; m_last = 1; m_ov = 0; m_od = 0;
    m_oid = 0; m_c0 = 0; m_c1 = 0;
  endtask

  function automatic int m_rev(input int d);
    int r = 0;
    int x = d;
    for (int k = 0; k < 11; k++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic int m_win();
    if (m_own == 0) return req0_valid ? 0 : -1;
    if (m_own == 1) return req1_valid ? 1 : -1;
    if (req0_valid && req1_valid) return 1 - m_last;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic bit m_can();
    return (m_ov == 0) || (out_ready == 1'b1);
  endfunction

  task automatic m_adv();
    int w;
    int d;
    w = m_can() ? m_win() : -1;
    if (w >= 0) begin
      d = (w == 1) ? int'(req1_data) : int'(req0_data);
      m_od = cfg_rev[w] ? m_rev(d) : d;
      m_oid = w;
      m_ov = 1;
      m_last = w;
      if (w == 0) m_c0 = (m_c0 + 1) % 65536;
      else m_c1 = (m_c1 + 1) % 65536;
      if ((w == 1) ? req1_lock : req0_lock) m_own = w;
      else m_own = -1;
    end else if (out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk20ns);
    m_adv();
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_lock = 0; req1_lock = 0;
    out_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    @(negedge clk20ns);
    rst_n = 1;
    m_reset();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk20ns);
    n_total++;
    if (out_valid !== 0 || out_data !== 0 || out_id !== 0) begin
      $display("FAIL reset_out: v=%0b d=%h id=%0b want 0/000/0",
               out_valid, out_data, out_id);
    end else n_pass++;
    n_total++;
    if (cnt0 !== 0 || cnt1 !== 0) begin
      $display("FAIL reset_cnt: cnt0=%0d cnt1=%0d want 0/0",
               cnt0, cnt1);
    end else n_pass++;
    req0_valid = 1; req1_valid = 1;
    rst_n = 1;
    m_reset();
    #1;
    n_total++;
    if (req0_ready !== 1 || req1_ready !== 0) begin
      $display("FAIL reset_first_grant: r0=%0b r1=%0b want 1/0",
               req0_ready, req1_ready);
    end else n_pass++;
    req0_valid = 0; req1_valid = 0;
    tick();
  endtask

  task automatic test_reversal();
    cfg_rev = 2'b01; out_ready = 1;
    req0_valid = 1; req0_data = 11'h001;
    @(negedge clk20ns);
    n_total++;
    if (req0_ready !== 1) begin
      $display("FAIL rev_ready0: got %0b want 1", req0_ready);
    end else n_pass++;
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_data = 11'h001;
    @(negedge clk20ns);
    n_total++;
    if (out_valid !== 1 || out_data !== 11'h400 || out_id !== 0) begin
      $display("FAIL rev_out0: v=%0b d=%h id=%0b want 1/400/0",
               out_valid, out_data, out_id);
    end else n_pass++;
    tick();
    req1_valid = 0;
    @(negedge clk20ns);
    n_total++;
    if (out_valid !== 1 || out_data !== 11'h001 || out_id !== 1) begin
      $display("FAIL pass_out1: v=%0b d=%h id=%0b want 1/001/1",
               out_valid, out_data, out_id);
    end else n_pass++;
    tick();
  endtask

  task automatic test_fairness();
    do_reset();
    cfg_rev = 2'($urandom);
    req0_valid = 1; req1_valid = 1; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      req0_data = 11'($urandom);
      req1_data = 11'($urandom);
      @(negedge clk20ns);
      n_total++;
      if (req0_ready !== ((i % 2) == 0) ||
          req1_ready !== ((i % 2) == 1)) begin
        $display("FAIL fair_grant[%0d]: r0=%0b r1=%0b want id %0d",
                 i, req0_ready, req1_ready, i % 2);
      end else n_pass++;
      if (i > 0) begin
        n_total++;
        if (out_id !== 1'((i - 1) % 2) || out_data !== 11'(m_od)) begin
          $display("FAIL fair_out[%0d]: id=%0b d=%h want %0d/%h",
                   i, out_id, out_data, (i - 1) % 2, m_od);
        end else n_pass++;
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk20ns);
    n_total++;
    if (cnt0 !== 4 || cnt1 !== 4) begin
      $display("FAIL fair_cnt: cnt0=%0d cnt1=%0d want 4/4", cnt0, cnt1);
    end else n_pass++;
    tick();
  endtask

  task automatic test_back_pressure();
    int hd, hid;
    out_ready = 1; req0_valid = 1; req0_data = 11'($urandom);
    tick();
    hd = m_od; hid = m_oid;
    out_ready = 0; req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      req0_data = 11'($urandom);
      req1_data = 11'($urandom);
      @(negedge clk20ns);
      n_total++;
      if (req0_ready !== 0 || req1_ready !== 0 || out_valid !== 1 ||
          out_data !== 11'(hd) || out_id !== 1'(hid)) begin
        $display("FAIL bp_hold[%0d]: r=%0b%0b v=%0b d=%h id=%0b want 00/1/%h/%0d",
                 i, req0_ready, req1_ready, out_valid, out_data,
                 out_id, hd, hid);
      end else n_pass++;
      tick();
    end
    out_ready = 1;
    @(negedge clk20ns);
    n_total++;
    if ((req0_ready | req1_ready) !== 1 ||
        req0_ready !== (m_win() == 0)) begin
      $display("FAIL bp_release: r0=%0b r1=%0b want winner %0d",
               req0_ready, req1_ready, m_win());
    end else n_pass++;
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
  endtask

  task automatic test_lock_burst();
    bit v0[9] = '{1, 1, 0, 0, 0, 1, 1, 1, 0};
    bit lk[9] = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
    int ex[9] = '{0, 0, -1, -1, -1, 0, 0, 1, 1};
    int got;
    do_reset();
    out_ready = 1; req1_valid = 1;
    for (int i = 0; i < 9; i++) begin
      req0_valid = v0[i]; req0_lock = lk[i];
      req0_data = 11'($urandom); req1_data = 11'($urandom);
      @(negedge clk20ns);
      got = req0_ready ? 0 : (req1_ready ? 1 : -1);
      n_total++;
      if (got !== ex[i] || (req0_ready && req1_ready)) begin
        $display("FAIL lock_grant[%0d]: got %0d want %0d", i, got, ex[i]);
      end else n_pass++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    bit e0, e1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_lock = ($urandom_range(0, 3) == 0);
      req1_lock = ($urandom_range(0, 3) == 0);
      req0_data = 11'($urandom);
      req1_data = 11'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) cfg_rev = 2'($urandom);
      @(negedge clk20ns);
      e0 = (m_win() == 0) && m_can();
      e1 = (m_win() == 1) && m_can();
      n_total++;
      if (req0_ready !== e0 || req1_ready !== e1) begin
        $display("FAIL rnd_ready[%0d]: r=%0b%0b want %0b%0b",
                 i, req0_ready, req1_ready, e0, e1);
      end else n_pass++;
      n_total++;
      if (out_valid !== 1'(m_ov) ||
          (m_ov == 1 && (out_data !== 11'(m_od) ||
                         out_id !== 1'(m_oid)))) begin
        $display("FAIL rnd_out[%0d]: v=%0b d=%h id=%0b want %0d/%h/%0d",
                 i, out_valid, out_data, out_id, m_ov, m_od, m_oid);
      end else n_pass++;
      n_total++;
      if (cnt0 !== 16'(m_c0) || cnt1 !== 16'(m_c1) ||
          x_cnt0 !== 4'(m_c0 % 16) || x_cnt1 !== 4'(m_c1 % 16)) begin
        $display("FAIL rnd_cnt[%0d]: %0d %0d %0d %0d want %0d %0d",
                 i, cnt0, cnt1, x_cnt0, x_cnt1, m_c0, m_c1);
      end else n_pass++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req1_valid = 1; out_ready = 1;
    for (int i = 0; i < 17; i++) begin
      req1_data = 11'($urandom);
      tick();
    end
    req1_valid = 0;
    @(negedge clk20ns);
    n_total++;
    if (x_cnt1 !== 4'd1 || cnt1 !== 16'd17) begin
      $display("FAIL wrap_cnt: cnt1_w4=%0d cnt1=%0d want 1/17",
               x_cnt1, cnt1);
    end else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 0;
    req1_valid = 1; req1_lock = 1; req1_data = 11'($urandom);
    tick();
    req1_valid = 0; req1_lock = 0;
    @(negedge clk20ns);
    n_total++;
    if (out_valid !== 1) begin
      $display("FAIL rmid_pre: out_valid=%0b want 1", out_valid);
    end else n_pass++;
    #3 rst_n = 0;
    #1;
    n_total++;
    if (out_valid !== 0 || x_out_valid !== 0) begin
      $display("FAIL rmid_async: out_valid=%0b/%0b want 0",
               out_valid, x_out_valid);
    end else n_pass++;
    #1 rst_n = 1;
    m_reset();
    req0_valid = 1; req1_valid = 1; out_ready = 1;
    #1;
    n_total++;
    if (req0_ready !== 1 || req1_ready !== 0) begin
      $display("FAIL rmid_grant: r0=%0b r1=%0b want 1/0",
               req0_ready, req1_ready);
    end else n_pass++;
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    m_reset();
    test_reset();
    test_reversal();
    test_fairness();
    test_back_pressure();
    test_lock_burst();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_girovettori_arbiter.md
Name: vga_girovettori_arbiter

Overview:
- Shares one registered 11-bit bit-reversal stage between two requesters in the VGA test path, e.g. the horizontal and vertical coordinate generators.
- Bit reversal: out[n] = in[W-1-n].
- Round-robin arbitration, with an optional burst lock so one requester can hold the stage for a whole scanline.
- Per-requester configuration selects reversal or pass-through. The result carries the winner's id on a valid/ready output.

Parameters:
- W, 11, data width of requests and result.
- CNT_W, 16, width of the per-requester accepted-beat counters.

Ports:
- clk20ns  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- req0_valid  in  1  requester 0 has data.
- req0_data  in  W  requester 0 word.
- req0_lock  in  1  requester 0 wants to keep the grant after this beat.
- req0_ready  out  1  requester 0 beat accepted this cycle.
- req1_valid, req1_data, req1_lock, req1_ready  same as above, for requester 1.
- cfg_rev  in  2  bit i=1: reverse requester i data; bit i=0: pass-through.
- out_valid  out  1  result register holds a word.
- out_data  out  W  result word.
- out_id  out  1  requester that produced out_data.
- out_ready  in  1  downstream takes the result.
- cnt0, cnt1  out  CNT_W  beats accepted from each requester.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_id=0, cnt0=cnt1=0, state=RR, last_grant=1 (requester 0 wins first).
- can_accept = !out_valid | out_ready. This is a single output register with no skid buffer, so full throughput is 1 beat/cycle while out_ready=1.
- Grant is combinational from the current valids, state and last_grant:
  - RR, both valid: grant = ~last_grant.
  - RR, one valid: grant = that requester.
  - RR, none valid: no grant.
  - HOLD0 / HOLD1: only requester 0 / 1 may be granted. The other requester waits even if valid.
- reqi_ready = grant==i & reqi_valid & can_accept. At most one ready is high per cycle.
- Accept (reqi_valid & reqi_ready), on the next edge:
  - out_data = cfg_rev[i] ? bitrev(reqi_data) : reqi_data, with cfg_rev sampled at accept.
  - out_id = i, out_valid = 1, last_grant = i, cnti += 1.
- Counters wrap modulo 2^CNT_W.
- out_valid=1 & out_ready=0 & no accept: out_data and out_id are held stable.
- out_ready=1 & no accept: out_valid goes to 0 next cycle.
- Accept and out_ready in the same cycle: the register is replaced. No bubble.
- Latency: exactly 1 cycle from accept to out_valid.
- State machine (state, last_grant and counters update only on an accept edge):
  - RR → HOLDi: on accept from i with reqi_lock=1.
  - HOLDi → RR: on accept from i with reqi_lock=0. last_grant=i, so the other requester wins next if valid.
  - HOLDi with reqi_valid=0: stays HOLDi. The lock is not broken by idle cycles.
- A cfg_rev change mid-stream affects only beats accepted after the change.
- Asserting rst_n mid-operation drops any pending result (out_valid=0 immediately) and clears HOLD.

Decomposition:
- Shared package vga_pkg:
  - localparam VGA_BUS_W=11.
  - State encoding ST_RR=2'd0, ST_HOLD0=2'd1, ST_HOLD1=2'd2.
  - Function bitrev (for loop over W).
- Sub-module rr_grant2: combinational 2-way grant from valid, state and last_grant.
- The datapath and FSM stay in the top module.

Test Plan:
- Reversal and pass-through: cfg_rev=2'b01, req0_data=11'h001 → out_data=11'h400, out_id=0, one cycle later. Then req1_data=11'h001 → out_data=11'h001, out_id=1.
- Fairness: both valid continuously, lock=0, out_ready=1 → out_id alternates 0,1,0,1 from reset. After 8 beats cnt0=cnt1=4. One ready per cycle.
- Back-pressure: out_ready=0 for 5 cycles with out_valid=1 → out_data and out_id unchanged, both readys 0. Release → the next beat is accepted in the same cycle out_ready rises.
- Lock burst: req0 sends 4 beats with lock=1,1,1,0 while req1 is valid throughout → out_id=0,0,0,0 then 1. A 3-cycle req0_valid gap inside the burst keeps req1 blocked.
- Counter wrap: CNT_W=4, 17 beats from req1 → cnt1=1.
- Reset mid-burst: assert rst_n=0 while in HOLD1 with out_valid=1 → out_valid=0 asynchronously. After release with both valid, the first grant goes to req0.
